data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 8-bit words stored (power of two, 2..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before acknowledge (0..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cyc_i  input  1  bus cycle in progress, from the initiator.
REQ-006 SHALL have port stb_i  input  1  transfer strobe, from the initiator.
REQ-007 SHALL have port we_i  input  1  1 = write (store), 0 = read (load).
REQ-008 SHALL have port adr_i  input  8  word address.
REQ-009 SHALL have port dat_i  input  8  write data.
REQ-010 SHALL have port dat_o  output  8  read data.
REQ-011 SHALL have port ack_o  output  1  transfer acknowledge, one-cycle pulse.
REQ-012 SHALL have port err_o  output  1  error acknowledge, one-cycle pulse (see REQ-030).

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT and ACK.
REQ-014 SHALL treat a request as present only when cyc_i and stb_i are both 1; stb_i without cyc_i is ignored.
REQ-015 In IDLE with a request at rising edge N, SHALL latch adr_i, we_i and dat_i, then go to ACK if WAIT_CYCLES = 0, else to WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to ACK on the edge where the counter reads 0.
REQ-017 SHALL assert ack_o for exactly the one cycle following edge N+WAIT_CYCLES (registered, never combinational from inputs).
REQ-018 On a latched write, SHALL commit dat to the array on the edge entering ACK.
REQ-019 On a latched read, SHALL load dat_o from the array on the edge entering ACK; dat_o holds that value until the next completed read.
REQ-020 SHALL go from ACK to IDLE unconditionally; a request still present during ACK is not re-accepted until sampled in IDLE (minimum spacing WAIT_CYCLES+2 cycles).
REQ-021 SHALL ignore changes on adr_i, we_i and dat_i after the latching edge.
REQ-022 If cyc_i is 0 at any edge in WAIT, SHALL abort to IDLE with no write, no ack_o and no err_o.
REQ-023 SHALL never assert ack_o and err_o in the same cycle.
REQ-024 For addresses below DEPTH, SHALL use adr_i[log2(DEPTH)-1:0] as the array index.

Reset
REQ-025 Assertion of rst (low) SHALL immediately force state IDLE, counter 0, ack_o 0, err_o 0 and dat_o 8'h00, regardless of clk.
REQ-026 Reset SHALL NOT clear array contents; a write interrupted by reset before entering ACK SHALL NOT commit.
REQ-027 After rst deasserts, the first request SHALL be accepted no earlier than the first rising edge with rst high.

Configuration
REQ-028 SHALL recognise macro DATA_MEM_RESP_ERR_EN.
REQ-029 Without DATA_MEM_RESP_ERR_EN, addresses at or above DEPTH SHALL wrap modulo DEPTH and complete normally with ack_o; err_o is tied 0.
REQ-030 With DATA_MEM_RESP_ERR_EN, addresses at or above DEPTH SHALL follow the same timing but pulse err_o instead of ack_o, perform no write, and leave dat_o unchanged.

Structure
REQ-031 SHALL take from shared package dmem_pkg the state enum type, DATA_W = 8 and ADDR_W = 8.
REQ-032 SHALL instantiate one sub-module, dmem_array: single-port storage with a synchronous write-enable and a registered read.
REQ-033 The FSM, wait counter, latches and range check SHALL reside in data_mem_resp.

Verification
REQ-034 Write then read, WAIT_CYCLES=1: write 8'hA5 to adr 8'h10 -> ack_o in cycle N+2; read adr 8'h10 -> ack_o in cycle N+2 with dat_o = 8'hA5.
REQ-035 Zero wait, WAIT_CYCLES=0: read adr 8'h00 after writing 8'h3C -> ack_o in the cycle after the sampling edge, dat_o = 8'h3C.
REQ-036 Abort: WAIT_CYCLES=3, write 8'hFF to adr 8'h20, drop cyc_i after 1 cycle -> no ack_o; a following read of adr 8'h20 returns its old value.
REQ-037 Reset mid-wait: WAIT_CYCLES=2, assert rst one cycle after a write request -> ack_o 0, dat_o 8'h00, array location unchanged.
REQ-038 Out of range, DEPTH=64: write 8'h77 to adr 8'h50 -> with DATA_MEM_RESP_ERR_EN, err_o pulses and adr 8'h10 is unchanged; without it, ack_o pulses and adr 8'h10 reads 8'h77.
REQ-039 Held strobe: keep cyc_i/stb_i high across ACK -> exactly one ack_o per IDLE acceptance, spacing WAIT_CYCLES+2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data memory responder.
package dmem_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_e;

   // One latched bus request
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] dat;
   } req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port byte storage: synchronous write, registered read port.
// Contents survive reset; only the read register is cleared.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   // Read data holds until the next completed read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Bus responder in front of a byte array: IDLE/WAIT/ACK handshake with wait states.
// Define DATA_MEM_RESP_ERR_EN to answer out-of-range addresses with err_o instead of wrapping.
module data_mem_resp
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] adr_i,
   input  logic [DATA_W-1:0] dat_i,
   output logic [DATA_W-1:0] dat_o,
   output logic              ack_o,
   output logic              err_o
);

   localparam int unsigned      IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? CNT_W'(0)
                                                               : CNT_W'(WAIT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_t             req_q, req_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;

   logic             req_c;
   logic             enter_ack_c;
   logic             oor_c;
   req_t             txn_c;
   logic             wr_en_c;
   logic             rd_en_c;

   assign req_c = cyc_i & stb_i;

   // With zero wait states the access completes on the latching edge, so use live inputs in IDLE
   assign txn_c = (state_q == IDLE) ? '{we: we_i, adr: adr_i, dat: dat_i} : req_q;

`ifdef DATA_MEM_RESP_ERR_EN
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   assign oor_c = ({1'b0, txn_c.adr} >= DEPTH_L);
`else
   assign oor_c = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      enter_ack_c = 1'b0;
      ack_d       = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_c) begin
               req_d = txn_c;
               if (WAIT_CYCLES == 0) begin
                  state_d     = ACK;
                  enter_ack_c = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            // Dropping cyc_i abandons the access silently
            if (!cyc_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d     = ACK;
               enter_ack_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      ack_d = enter_ack_c & ~oor_c;
      err_d = enter_ack_c & oor_c;
   end

   assign wr_en_c = enter_ack_c & ~oor_c & txn_c.we;
   assign rd_en_c = enter_ack_c & ~oor_c & ~txn_c.we;

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en_c),
      .re_i    (rd_en_c),
      .idx_i   (IDX_W'(txn_c.adr)),
      .wdata_i (txn_c.dat),
      .rdata_o (dat_o)
   );

   assign ack_o = ack_q;
   assign err_o = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench: four responder instances with different depth / wait settings
// checked against a transaction-level model of memory contents and response timing.
module tb_data_mem_resp;

   localparam int NDUT = 4;
   localparam int DEP [NDUT] = '{256, 64, 64, 256};
   localparam int WT  [NDUT] = '{1, 0, 3, 2};

   logic       clk;
   logic       rst;
   logic       cyc   [NDUT];
   logic       stb   [NDUT];
   logic       we_s  [NDUT];
   logic [7:0] adr_s [NDUT];
   logic [7:0] dat_s [NDUT];
   logic [7:0] dat_w [NDUT];
   logic       ack_w [NDUT];
   logic       err_w [NDUT];

   logic [7:0] mem_m   [NDUT][256];
   bit         known_m [NDUT][256];
   logic [7:0] dat_m   [NDUT];

   int n_run;
   int n_fail;

   data_mem_resp #(.DEPTH(DEP[0]), .WAIT_CYCLES(WT[0])) u_d0 (
      .clk(clk), .rst(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we_s[0]),
      .adr_i(adr_s[0]), .dat_i(dat_s[0]), .dat_o(dat_w[0]), .ack_o(ack_w[0]), .err_o(err_w[0]));
   data_mem_resp #(.DEPTH(DEP[1]), .WAIT_CYCLES(WT[1])) u_d1 (
      .clk(clk), .rst(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we_s[1]),
      .adr_i(adr_s[1]), .dat_i(dat_s[1]), .dat_o(dat_w[1]), .ack_o(ack_w[1]), .err_o(err_w[1]));
   data_mem_resp #(.DEPTH(DEP[2]), .WAIT_CYCLES(WT[2])) u_d2 (
      .clk(clk), .rst(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we_s[2]),
      .adr_i(adr_s[2]), .dat_i(dat_s[2]), .dat_o(dat_w[2]), .ack_o(ack_w[2]), .err_o(err_w[2]));
   data_mem_resp #(.DEPTH(DEP[3]), .WAIT_CYCLES(WT[3])) u_d3 (
      .clk(clk), .rst(rst), .cyc_i(cyc[3]), .stb_i(stb[3]), .we_i(we_s[3]),
      .adr_i(adr_s[3]), .dat_i(dat_s[3]), .dat_o(dat_w[3]), .ack_o(ack_w[3]), .err_o(err_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_err(input int d, input logic [7:0] adr);
`ifdef DATA_MEM_RESP_ERR_EN
      return int'(adr) >= DEP[d];
`else
      return 1'b0;
`endif
   endfunction

   // One complete transaction; response expected W cycles after the accepting edge
   task automatic do_txn(input int d, input logic we, input logic [7:0] adr,
                         input logic [7:0] dat, input string nm);
      int         w;
      int         idx;
      bit         e;
      logic [7:0] new_dat;
      w   = WT[d];
      idx = int'(adr) % DEP[d];
      e   = is_err(d, adr);
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we_s[d] = we; adr_s[d] = adr; dat_s[d] = dat;
      @(posedge clk);
      new_dat = dat_m[d];
      if (!e) begin
         if (we) begin
            mem_m[d][idx] = dat; known_m[d][idx] = 1'b1;
         end else begin
            new_dat = mem_m[d][idx];
         end
      end
      for (int i = 0; i <= w + 1; i++) begin
         @(negedge clk);
         n_run++;
         if (ack_w[d] !== (i == w && !e)) begin
            n_fail++;
            $display("FAIL %s ack d%0d cyc%0d: got %b want %b", nm, d, i, ack_w[d], (i == w && !e));
         end
         n_run++;
         if (err_w[d] !== (i == w && e)) begin
            n_fail++;
            $display("FAIL %s err d%0d cyc%0d: got %b want %b", nm, d, i, err_w[d], (i == w && e));
         end
         n_run++;
         if (dat_w[d] !== ((i >= w) ? new_dat : dat_m[d])) begin
            n_fail++;
            $display("FAIL %s dat_o d%0d cyc%0d: got %h want %h", nm, d, i, dat_w[d],
                     (i >= w) ? new_dat : dat_m[d]);
         end
         if (i == 0) begin
            we_s[d] = 1'($urandom); adr_s[d] = 8'($urandom); dat_s[d] = 8'($urandom);
         end
         if (i == w) begin
            cyc[d] = 1'b0; stb[d] = 1'b0;
         end
      end
      dat_m[d] = new_dat;
   endtask

   task automatic test_reset();
      #3;
      for (int d = 0; d < NDUT; d++) begin
         n_run++;
         if (ack_w[d] !== 1'b0 || err_w[d] !== 1'b0 || dat_w[d] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset d%0d: got ack=%b err=%b dat=%h want 0 0 00", d, ack_w[d], err_w[d], dat_w[d]);
         end
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_write_read();
      do_txn(0, 1'b1, 8'h10, 8'hA5, "wr_w1");
      do_txn(0, 1'b0, 8'h10, 8'h00, "rd_w1");
   endtask

   task automatic test_zero_wait();
      do_txn(1, 1'b1, 8'h00, 8'h3C, "wr_w0");
      do_txn(1, 1'b0, 8'h00, 8'h00, "rd_w0");
   endtask

   task automatic test_abort();
      do_txn(2, 1'b1, 8'h20, 8'h11, "pre_abort");
      @(negedge clk);
      cyc[2] = 1'b1; stb[2] = 1'b1; we_s[2] = 1'b1; adr_s[2] = 8'h20; dat_s[2] = 8'hFF;
      @(negedge clk);
      cyc[2] = 1'b0; stb[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_run++;
         if (ack_w[2] !== 1'b0 || err_w[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort resp cyc%0d: got ack=%b err=%b want 0 0", i, ack_w[2], err_w[2]);
         end
      end
      do_txn(2, 1'b0, 8'h20, 8'h00, "rd_after_abort");
   endtask

   task automatic test_reset_mid_wait();
      do_txn(3, 1'b1, 8'h30, 8'h5A, "pre_rst");
      do_txn(3, 1'b0, 8'h30, 8'h00, "rd_pre_rst");
      @(negedge clk);
      cyc[3] = 1'b1; stb[3] = 1'b1; we_s[3] = 1'b1; adr_s[3] = 8'h30; dat_s[3] = 8'hC3;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         dat_m[d] = 8'h00;
         n_run++;
         if (ack_w[d] !== 1'b0 || err_w[d] !== 1'b0 || dat_w[d] !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid d%0d: got ack=%b err=%b dat=%h want 0 0 00", d, ack_w[d], err_w[d], dat_w[d]);
         end
      end
      @(negedge clk);
      @(negedge clk);
      cyc[3] = 1'b0; stb[3] = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_run++;
         if (ack_w[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid ack after release cyc%0d: got %b want 0", i, ack_w[3]);
         end
      end
      do_txn(3, 1'b0, 8'h30, 8'h00, "rd_after_rst");
   endtask

   task automatic test_out_of_range();
      do_txn(1, 1'b1, 8'h10, 8'h01, "pre_oor");
      do_txn(1, 1'b1, 8'h50, 8'h77, "wr_oor");
      do_txn(1, 1'b0, 8'h10, 8'h00, "rd_alias");
      do_txn(1, 1'b0, 8'h50, 8'h00, "rd_oor");
   endtask

   task automatic test_strobe_only();
      @(negedge clk);
      cyc[0] = 1'b0; stb[0] = 1'b1; we_s[0] = 1'b1; adr_s[0] = 8'h10; dat_s[0] = 8'hEE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_run++;
         if (ack_w[0] !== 1'b0 || err_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stb_only cyc%0d: got ack=%b err=%b want 0 0", i, ack_w[0], err_w[0]);
         end
      end
      stb[0] = 1'b0;
      do_txn(0, 1'b0, 8'h10, 8'h00, "rd_after_stb_only");
   endtask

   // Held request: one response per acceptance, W+2 cycles apart
   task automatic test_back_to_back();
      logic [7:0] v;
      for (int d = 0; d < NDUT; d++) begin
         v = 8'($urandom);
         @(negedge clk);
         cyc[d] = 1'b1; stb[d] = 1'b1; we_s[d] = 1'b1; adr_s[d] = 8'h05; dat_s[d] = v;
         for (int k = 0; k < 3 * (WT[d] + 2); k++) begin
            @(negedge clk);
            n_run++;
            if (ack_w[d] !== ((k % (WT[d] + 2)) == WT[d])) begin
               n_fail++;
               $display("FAIL held d%0d edge%0d: got ack=%b want %b", d, k, ack_w[d],
                        ((k % (WT[d] + 2)) == WT[d]));
            end
         end
         cyc[d] = 1'b0; stb[d] = 1'b0;
         mem_m[d][5] = v; known_m[d][5] = 1'b1;
         do_txn(d, 1'b0, 8'h05, 8'h00, "rd_after_held");
      end
   endtask

   task automatic test_random();
      int         d;
      logic       we;
      logic [7:0] adr;
      int         idx;
      for (int n = 0; n < 60; n++) begin
         d   = int'($urandom_range(0, NDUT - 1));
         adr = (DEP[d] < 256 && ($urandom % 2) == 1) ? 8'($urandom_range(0, 127)) : 8'($urandom);
         we  = 1'($urandom);
         idx = int'(adr) % DEP[d];
         if (!we && !is_err(d, adr) && !known_m[d][idx]) we = 1'b1;
         do_txn(d, we, adr, 8'($urandom), "random");
      end
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst    = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0; we_s[d] = 1'b0; adr_s[d] = 8'h00; dat_s[d] = 8'h00;
         dat_m[d] = 8'h00;
         for (int a = 0; a < 256; a++) begin
            mem_m[d][a] = 8'h00; known_m[d][a] = 1'b0;
         end
      end
      test_reset();
      test_write_read();
      test_zero_wait();
      test_abort();
      test_reset_mid_wait();
      test_out_of_range();
      test_strobe_only();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
